// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file slice.
// Sweep FSM encoding and default geometry.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared
// by writeback, flushed when a clear sweep starts.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD-1:0]    pend
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Set is applied after clear so a same-edge reserve wins.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (clr_en) pend_d[clr_addr] = 1'b0;
      if (set_en) pend_d[set_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < NRD; i++) begin
      pend[i] = pend_q[raddr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with issue scoreboard and clear sweep.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to readers.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rpend,
  input  logic                  rsv,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DATA_W-1:0] entry_d [DEPTH];

  logic              idle;
  logic              wr_en;
  logic              rsv_en;
  logic              flush;
  logic [NRD-1:0]    sb_pend;
  logic [ADDR_W-1:0] ra;

  assign idle     = (state_q == IDLE);
  assign wr_en    = idle && we && (waddr != '0);
  assign rsv_en   = idle && rsv && (rsv_addr != '0);
  assign flush    = idle && clr_req;
  assign clr_busy = (state_q == CLEAR);

  always_comb begin
    entry_d = entry_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en) entry_d[waddr] = wdata;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        entry_d[cnt_q] = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rsv_en),
    .set_addr (rsv_addr),
    .clr_en   (wr_en),
    .clr_addr (waddr),
    .flush    (flush),
    .raddr    (raddr),
    .pend     (sb_pend)
  );

  always_comb begin
    rdata = '0;
    rpend = '0;
    ra    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      if (ra != '0) begin
        rdata[i*DATA_W +: DATA_W] = entry_q[ra];
        rpend[i] = sb_pend[i];
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (ra == waddr)) begin
        rdata[i*DATA_W +: DATA_W] = wdata;
        rpend[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp against an array model.
// Honours REG_FILE_BYPASS_EN when computing same-cycle read expectations.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]   rpend;
  logic            rsv;
  logic [AW-1:0]   rsv_addr;
  logic            clr_req;
  logic            clr_busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_busy;
  int            m_idx;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rpend    (rpend),
    .rsv      (rsv),
    .rsv_addr (rsv_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  function automatic bit byp_hit(input logic [AW-1:0] a);
`ifdef REG_FILE_BYPASS_EN
    return !m_busy && we && (waddr == a) && (a != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (byp_hit(a)) return wdata;
    if (a == 0) return '0;
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(input logic [AW-1:0] a);
    if (byp_hit(a) || a == 0) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_idx = 0;
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; rsv = 0; rsv_addr = 0;
    clr_req = 0; raddr = 0;
  endtask

  // Apply one clock edge to the model, then advance the DUT past it.
  task automatic tick();
    if (!m_busy) begin
      if (we && waddr != 0) begin
        m_mem[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (rsv && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin
        m_busy = 1'b1;
        m_idx = 0;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
      end
    end else begin
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) begin
        m_busy = 1'b0;
        m_idx = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0b want 0", clr_busy);
    end
    for (int a = 0; a < DEPTH; a += 3) begin
      raddr = {AW'(a + 1), AW'(a)};
      #1;
      checks++;
      if (rdata !== '0 || rpend !== '0) begin
        errors++;
        $display("FAIL reset_read a=%0d got %h/%b want 0/0", a, rdata, rpend);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_write();
    we = 1; waddr = 2; wdata = 32'hABCD1234;
    tick();
    idle_inputs();
    raddr = {AW'(0), AW'(2)};
    #1;
    checks++;
    if (rdata[DW-1:0] !== 32'hABCD1234 || rpend[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_write got %h/%b want abcd1234/0",
               rdata[DW-1:0], rpend[0]);
    end
  endtask

  task automatic test_r0();
    we = 1; waddr = 0; wdata = '1; rsv = 1; rsv_addr = 0;
    tick();
    idle_inputs();
    raddr = {AW'(0), AW'(0)};
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      errors++;
      $display("FAIL r0_hardwired got %h/%b want 0/0", rdata, rpend);
    end
  endtask

  task automatic test_reserve();
    rsv = 1; rsv_addr = 5;
    tick();
    idle_inputs();
    raddr = {AW'(6), AW'(5)};
    #1;
    checks++;
    if (rpend !== 2'b01) begin
      errors++;
      $display("FAIL reserve_set got %b want 01", rpend);
    end
    we = 1; waddr = 5; wdata = 32'h55;
    tick();
    idle_inputs();
    raddr = {AW'(6), AW'(5)};
    #1;
    checks++;
    if (rpend[0] !== 1'b0 || rdata[DW-1:0] !== 32'h55) begin
      errors++;
      $display("FAIL reserve_wb got %h/%b want 55/0", rdata[DW-1:0], rpend[0]);
    end
    we = 1; waddr = 6; wdata = 32'h600D; rsv = 1; rsv_addr = 6;
    tick();
    idle_inputs();
    raddr = {AW'(5), AW'(6)};
    #1;
    checks++;
    if (rpend !== 2'b01 || rdata[DW-1:0] !== 32'h600D) begin
      errors++;
      $display("FAIL same_edge_wr_rsv got %h/%b want 600d/01",
               rdata[DW-1:0], rpend);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
`ifdef REG_FILE_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'h0;
`endif
    we = 1; waddr = 7; wdata = 32'h1234; raddr = {AW'(0), AW'(7)};
    #1;
    checks++;
    if (rdata[DW-1:0] !== want) begin
      errors++;
      $display("FAIL bypass got %h want %h", rdata[DW-1:0], want);
    end
    tick();
    idle_inputs();
    raddr = {AW'(7), AW'(0)};
    #1;
    checks++;
    if (rdata[2*DW-1:DW] !== 32'h1234) begin
      errors++;
      $display("FAIL after_write got %h want 1234", rdata[2*DW-1:DW]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      we       = ($urandom_range(0, 2) != 0);
      waddr    = AW'($urandom_range(0, 9));
      wdata    = $urandom;
      rsv      = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 9));
      clr_req  = (!m_busy && $urandom_range(0, 99) == 0);
      raddr    = {AW'($urandom_range(0, 9)), AW'($urandom_range(0, 31))};
      #1;
      for (int p = 0; p < NR; p++) begin
        a = raddr[p*AW +: AW];
        checks++;
        if (rdata[p*DW +: DW] !== exp_data(a) || rpend[p] !== exp_pend(a)) begin
          errors++;
          $display("FAIL random n=%0d p=%0d a=%0d got %h/%b want %h/%b",
                   n, p, a, rdata[p*DW +: DW], rpend[p], exp_data(a),
                   exp_pend(a));
        end
      end
      checks++;
      if (clr_busy !== m_busy) begin
        errors++;
        $display("FAIL random_busy n=%0d got %b want %b", n, clr_busy, m_busy);
      end
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 40 && m_busy; k++) tick();
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int a = 1; a < DEPTH; a++) begin
      we = 1; waddr = AW'(a); wdata = 32'hC0DE0000 + a;
      rsv = 1; rsv_addr = AW'(DEPTH - a);
      tick();
    end
    idle_inputs();
    raddr = {AW'(31), AW'(1)};
    #1;
    checks++;
    if (rdata !== {32'hC0DE001F, 32'hC0DE0001}) begin
      errors++;
      $display("FAIL fill got %h want c0de001fc0de0001", rdata);
    end
    clr_req = 1;
    tick();
    clr_req = 0;
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      we = 1; waddr = AW'($urandom_range(1, 31)); wdata = $urandom;
      rsv = 1; rsv_addr = AW'($urandom_range(1, 31));
      raddr = {AW'(31), AW'(busy_cnt - 1)};
      #1;
      checks++;
      if (rdata !== {exp_data(31), exp_data(AW'(busy_cnt - 1))}) begin
        errors++;
        $display("FAIL sweep_read c=%0d got %h", busy_cnt, rdata);
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (busy_cnt != DEPTH) begin
      errors++;
      $display("FAIL clear_len got %0d want %0d", busy_cnt, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(a), AW'(a)};
      #1;
      checks++;
      if (rdata !== '0 || rpend !== '0) begin
        errors++;
        $display("FAIL cleared a=%0d got %h/%b want 0/0", a, rdata, rpend);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int a = 1; a < DEPTH; a += 2) begin
      we = 1; waddr = AW'(a); wdata = $urandom | 1;
      tick();
    end
    idle_inputs();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_busy got %b want 1", clr_busy);
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b want 0", clr_busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(a), AW'(a)};
      #1;
      checks++;
      if (rdata !== '0) begin
        errors++;
        $display("FAIL abort_data a=%0d got %h want 0", a, rdata);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_abort_busy got %b want 0", clr_busy);
    end
    we = 1; waddr = 9; wdata = 32'h9999;
    tick();
    idle_inputs();
    raddr = {AW'(9), AW'(9)};
    #1;
    checks++;
    if (rdata[DW-1:0] !== 32'h9999) begin
      errors++;
      $display("FAIL post_abort_write got %h want 9999", rdata[DW-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_r0();
    test_reserve();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of read ports (legal 1..4).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous reset, active-low (asserted when 0).
REQ-006 The block SHALL have port we  input  1  write enable.
REQ-007 The block SHALL have port waddr  input  ADDR_W  write address.
REQ-008 The block SHALL have port wdata  input  DATA_W  write data.
REQ-009 The block SHALL have port raddr  input  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port rdata  output  NRD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W].
REQ-011 The block SHALL have port rpend  output  NRD  port i's address has an outstanding reservation.
REQ-012 The block SHALL have port rsv  input  1  reserve destination (issue-time scoreboard set).
REQ-013 The block SHALL have port rsv_addr  input  ADDR_W  address to reserve.
REQ-014 The block SHALL have port clr_req  input  1  request a full clear sweep.
REQ-015 The block SHALL have port clr_busy  output  1  clear sweep in progress.

Function
REQ-016 Reads SHALL be combinational: rdata port i = entry[raddr i]; rpend i = pend[raddr i].
REQ-017 Address 0 SHALL be hardwired: reads return 0, rpend 0; writes and reservations to 0 ignored.
REQ-018 When we=1, waddr!=0, FSM IDLE: entry[waddr] <= wdata at the edge; visible on rdata the same cycle after that edge (one-edge latency without bypass).
REQ-019 A write (we=1, waddr!=0, IDLE) SHALL clear pend[waddr] at the same edge.
REQ-020 When rsv=1, rsv_addr!=0, FSM IDLE: pend[rsv_addr] <= 1.
REQ-021 Simultaneous write and reserve to the same address SHALL leave pend set (reserve wins) and store wdata.
REQ-022 Simultaneous write and reserve to different addresses SHALL apply both.
REQ-023 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after the edge that clears entry DEPTH-1.
REQ-024 In CLEAR, a counter starting at 0 SHALL zero one entry per cycle, DEPTH cycles total; clr_busy=1 exactly in CLEAR.
REQ-025 All pend bits SHALL be cleared at the IDLE->CLEAR edge.
REQ-026 A write or reserve presented in the same cycle as clr_req (IDLE) SHALL be performed, then overwritten by the sweep.
REQ-027 In CLEAR, we, rsv and clr_req SHALL be ignored; reads return current (partially cleared) contents.
REQ-028 Counter SHALL be ADDR_W bits and SHALL return to 0 on exit from CLEAR.

Reset
REQ-029 reset=0 SHALL immediately force all entries 0, all pend 0, FSM IDLE, counter 0, clr_busy 0.
REQ-030 reset asserted mid-sweep SHALL abort the sweep; after deassertion FSM is IDLE.
REQ-031 Outputs after reset: rdata all 0, rpend all 0, clr_busy 0.

Configuration
REQ-032 Macro REG_FILE_BYPASS_EN, when defined, SHALL forward wdata to any read port with raddr==waddr!=0 while we=1 in IDLE, and force that port's rpend to 0, same cycle.
REQ-033 Without REG_FILE_BYPASS_EN, read ports SHALL return stored contents only, old value until the write edge.

Structure
REQ-034 FSM state encoding (IDLE, CLEAR) and default parameter constants SHALL live in shared package reg_file_pkg.
REQ-035 One sub-module, reg_file_scoreboard (pend bits, set/clear/flush logic), SHALL be instantiated; storage and FSM stay in reg_file_mp.

Verification
REQ-036 Reset, write 0xABCD1234 to r2, read r2 on port 0 next cycle -> rdata0 0xABCD1234, rpend0 0.
REQ-037 Write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, rpend 0.
REQ-038 Reserve r5; read r5 -> rpend 1; write 0x55 to r5 -> rpend 0, rdata 0x55; same-edge write+reserve r6 -> rpend 1, rdata written value.
REQ-039 Bypass: with macro, we=1 waddr=7 wdata=0x1234, raddr0=7 same cycle -> rdata0 0x1234; without macro -> old value 0.
REQ-040 Fill r1..r31, pulse clr_req -> clr_busy high exactly 32 cycles, writes during CLEAR dropped, then all reads 0.
REQ-041 Assert reset at sweep cycle 10 -> clr_busy 0 immediately, all entries 0, FSM IDLE after deassertion.
